// File: rtl/event_flasher_pkg.sv
// Shared state encoding and default timing for the event flasher.
package event_flasher_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int ON_TICKS_DEF  = 3;
  localparam int GAP_TICKS_DEF = 2;
  localparam int PEND_W_DEF    = 4;
  localparam int CNT_W         = 8;

endpackage

// File: rtl/event_flasher_rise_detect.sv
// Rising-edge detector: one-cycle pulse on each 0->1 transition of d.
// pulse is combinational from d and the registered previous sample.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic d_prev_q;
  logic d_prev_d;

  always_comb begin
    d_prev_d = d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_prev_q <= 1'b0;
    end else begin
      d_prev_q <= d_prev_d;
    end
  end

  assign pulse = d & ~d_prev_q;

endmodule

// File: rtl/event_flasher.sv
// Queues single-cycle events and replays each as one LED flash timed in slow_clk ticks.
// First flash starts on the first tick after the event; events beyond the queue depth are dropped and flagged.
module event_flasher
  import event_flasher_pkg::*;
#(
  parameter int ON_TICKS  = ON_TICKS_DEF,
  parameter int GAP_TICKS = GAP_TICKS_DEF,
  parameter int PEND_W    = PEND_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              slow_clk,
  input  logic              evt_in,
  input  logic              ovf_clr,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam logic [CNT_W-1:0]  ON_LAST  = CNT_W'(ON_TICKS - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST = CNT_W'(GAP_TICKS - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PEND_W-1:0]  pend_q, pend_d;
  logic               ovf_q, ovf_d;
  logic               led_q, led_d;
  logic               busy_q, busy_d;
  logic               tick;
  logic               consume;
  logic               ovf_set;

  rise_detect u_tick (
    .clk   (clk),
    .rst   (rst),
    .d     (slow_clk),
    .pulse (tick)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    consume = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tick && pend_q != '0) begin
          state_d = ON;
          cnt_d   = '0;
          consume = 1'b1;
        end
      end
      ON: begin
        if (tick) begin
          if (cnt_q == ON_LAST) begin
            state_d = GAP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (cnt_q == GAP_LAST) begin
            cnt_d = '0;
            // Chain straight into the next flash so queued events leave no idle tick.
            if (pend_q != '0) begin
              state_d = ON;
              consume = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    led_d  = (state_d == ON);
    busy_d = (state_d != IDLE);
  end

  always_comb begin
    pend_d  = pend_q;
    ovf_set = 1'b0;
    if (evt_in && !consume) begin
      if (pend_q == PEND_MAX) begin
        ovf_set = 1'b1;
      end else begin
        pend_d = pend_q + 1'b1;
      end
    end else if (!evt_in && consume) begin
      pend_d = pend_q - 1'b1;
    end
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
    end
  end

  assign led_out  = led_q;
  assign busy     = busy_q;
  assign pending  = pend_q;
  assign overflow = ovf_q;

endmodule
